// File: rtl/voice_phase_sequencer.sv
// voice_phase_sequencer: per-frame voice scheduler and phase accumulator.
// Each sample tick walks all voices through a read/compute/write-back pipeline,
// presenting index, wave select and top phase bits to the wavetable stage.
// Note/control updates enter through a single-entry holding register.
module voice_phase_sequencer #(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned PHASE_W    = 24
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_sample_tick,
    input  logic               i_upd_valid,
    output logic               o_upd_ready,
    input  logic [7:0]         i_upd_voice,
    input  logic [PHASE_W-1:0] i_upd_delta,
    input  logic [3:0]         i_upd_wave,
    input  logic               i_upd_gate,
    output logic [7:0]         o_voice_index,
    output logic [1:0]         o_pipeline_state,
    output logic [9:0]         o_phase,
    output logic [3:0]         o_wave_select,
    output logic               o_voice_active,
    output logic               o_frame_busy,
    output logic               o_frame_done,
    output logic               o_tick_overrun
);

    typedef enum logic [1:0] {
        ST_S0   = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [7:0] voice_q, voice_d;
    logic done_q, done_d;
    logic overrun_q, overrun_d;

    logic [PHASE_W-1:0] acc_q   [NUM_VOICES];
    logic [PHASE_W-1:0] acc_d   [NUM_VOICES];
    logic [PHASE_W-1:0] delta_q [NUM_VOICES];
    logic [PHASE_W-1:0] delta_d [NUM_VOICES];
    logic [3:0]         wave_q  [NUM_VOICES];
    logic [3:0]         wave_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;

    logic [7:0] out_index_q, out_index_d;
    logic [9:0] out_phase_q, out_phase_d;
    logic [3:0] out_wave_q, out_wave_d;
    logic       out_active_q, out_active_d;

    logic               pend_q, pend_d;
    logic [7:0]         pvoice_q, pvoice_d;
    logic [PHASE_W-1:0] pdelta_q, pdelta_d;
    logic [3:0]         pwave_q, pwave_d;
    logic               pgate_q, pgate_d;

    logic       load_out;
    logic [7:0] rd_voice;
    logic       apply_upd;

    assign apply_upd = pend_q && (state_q == ST_IDLE || state_q == ST_S2);

    // Frame sequencing: next state, voice counter, done/overrun pulses.
    // Output registers are loaded on the edge that enters S0, so S0 already shows the voice.
    always_comb begin
        state_d   = state_q;
        voice_d   = voice_q;
        done_d    = 1'b0;
        overrun_d = i_sample_tick && (state_q != ST_IDLE);
        load_out  = 1'b0;
        rd_voice  = voice_q;
        case (state_q)
            ST_IDLE: begin
                if (i_sample_tick) begin
                    state_d  = ST_S0;
                    voice_d  = '0;
                    load_out = 1'b1;
                    rd_voice = '0;
                end
            end
            ST_S0: state_d = ST_S1;
            ST_S1: state_d = ST_S2;
            ST_S2: begin
                if (voice_q == 8'(NUM_VOICES - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_S0;
                    voice_d  = voice_q + 8'd1;
                    load_out = 1'b1;
                    rd_voice = voice_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered wavetable outputs: capture the selected voice's state, hold otherwise.
    always_comb begin
        out_index_d  = out_index_q;
        out_phase_d  = out_phase_q;
        out_wave_d   = out_wave_q;
        out_active_d = out_active_q;
        if (load_out) begin
            out_index_d = rd_voice;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (8'(i) == rd_voice) begin
                    out_phase_d  = acc_q[i][PHASE_W-1 -: 10];
                    out_wave_d   = wave_q[i];
                    out_active_d = gate_q[i];
                end
            end
        end
    end

    // Voice state: write-back accumulation, then update merge (update wins on
    // delta/wave/gate; a retrigger overrides the accumulated value).
    always_comb begin
        acc_d   = acc_q;
        delta_d = delta_q;
        wave_d  = wave_q;
        gate_d  = gate_q;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (state_q == ST_S2 && 8'(i) == voice_q && gate_q[i]) begin
                acc_d[i] = acc_q[i] + delta_q[i];
            end
            if (apply_upd && 8'(i) == pvoice_q) begin
                delta_d[i] = pdelta_q;
                wave_d[i]  = pwave_q;
                gate_d[i]  = pgate_q;
                if (!gate_q[i] && pgate_q) begin
                    acc_d[i] = '0;
                end
            end
        end
    end

    // Update holding register: accept when empty, clear once applied.
    always_comb begin
        pend_d   = pend_q;
        pvoice_d = pvoice_q;
        pdelta_d = pdelta_q;
        pwave_d  = pwave_q;
        pgate_d  = pgate_q;
        if (apply_upd) begin
            pend_d = 1'b0;
        end
        if (i_upd_valid && !pend_q) begin
            pend_d   = 1'b1;
            pvoice_d = i_upd_voice;
            pdelta_d = i_upd_delta;
            pwave_d  = i_upd_wave;
            pgate_d  = i_upd_gate;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            voice_q      <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                acc_q[i]   <= '0;
                delta_q[i] <= '0;
                wave_q[i]  <= '0;
            end
            gate_q       <= '0;
            out_index_q  <= '0;
            out_phase_q  <= '0;
            out_wave_q   <= '0;
            out_active_q <= 1'b0;
            pend_q       <= 1'b0;
            pvoice_q     <= '0;
            pdelta_q     <= '0;
            pwave_q      <= '0;
            pgate_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            voice_q      <= voice_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            acc_q        <= acc_d;
            delta_q      <= delta_d;
            wave_q       <= wave_d;
            gate_q       <= gate_d;
            out_index_q  <= out_index_d;
            out_phase_q  <= out_phase_d;
            out_wave_q   <= out_wave_d;
            out_active_q <= out_active_d;
            pend_q       <= pend_d;
            pvoice_q     <= pvoice_d;
            pdelta_q     <= pdelta_d;
            pwave_q      <= pwave_d;
            pgate_q      <= pgate_d;
        end
    end

    assign o_upd_ready      = !pend_q;
    assign o_voice_index    = out_index_q;
    assign o_pipeline_state = state_q;
    assign o_phase          = out_phase_q;
    assign o_wave_select    = out_wave_q;
    assign o_voice_active   = out_active_q;
    assign o_frame_busy     = (state_q != ST_IDLE);
    assign o_frame_done     = done_q;
    assign o_tick_overrun   = overrun_q;

endmodule
